// File: rtl/gpu_layer_pkg.sv
// Shared layer-record layout and sequencer state encoding for the layer scan path.
package gpu_layer_pkg;

  localparam int LAYER_W     = 128;
  localparam int POP_BIT     = 0;
  localparam int SPRITE_BIT  = 1;
  localparam int WIDTH_LSB   = 16;
  localparam int WIDTH_MSB   = 31;
  localparam int HEIGHT_LSB  = 32;
  localparam int HEIGHT_MSB  = 47;
  localparam int XPOS_LSB    = 48;
  localparam int XPOS_MSB    = 63;
  localparam int YPOS_LSB    = 64;
  localparam int YPOS_MSB    = 79;
  localparam int NCHAR_LSB   = 96;
  localparam int NCHAR_MSB   = 103;

  // Width of the bounding-box arithmetic; holds a 16-bit position plus a 24-bit extent.
  localparam int BOX_W = 25;

  typedef logic [LAYER_W-1:0] layer_regs_t;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, TEST, ISSUE, ADVANCE} seq_state_t;

endpackage

// File: rtl/layer_scan_sequencer_if.sv
// Register-file read port plus job handshake between the sequencer and the address unit.
interface layer_scan_sequencer_if
  import gpu_layer_pkg::*;
#(
  parameter int NUM_LAYERS = 16,
  parameter int PIX_W      = 9
);
  localparam int IDX_W = $clog2(NUM_LAYERS);

  logic [IDX_W-1:0] layer_rd_idx;
  logic             layer_rd_en;
  layer_regs_t      layer_rd_data;
  logic             job_valid;
  logic             acu_rdy;
  layer_regs_t      layerRegisters;
  logic [PIX_W-1:0] xPixel;
  logic [PIX_W-1:0] yPixel;
  logic [IDX_W-1:0] layer_idx;

  modport master (
    output layer_rd_idx, layer_rd_en, job_valid, layerRegisters, xPixel, yPixel, layer_idx,
    input  layer_rd_data, acu_rdy
  );

  modport slave (
    input  layer_rd_idx, layer_rd_en, job_valid, layerRegisters, xPixel, yPixel, layer_idx,
    output layer_rd_data, acu_rdy
  );

endinterface

// File: rtl/layer_scan_sequencer_hit_test.sv
// Combinational test of whether a pixel falls inside a layer's bounding box.
module layer_hit_test
  import gpu_layer_pkg::*;
#(
  parameter int PIX_W = 9
) (
  input  layer_regs_t      regs,
  input  logic [PIX_W-1:0] x,
  input  logic [PIX_W-1:0] y,
  output logic             hit
);

  logic [BOX_W-1:0] width, height, xpos, ypos, nchar, effw, x_end, y_end, xp, yp;
  logic             unused_fields;

  assign width  = BOX_W'(regs[WIDTH_MSB:WIDTH_LSB]);
  assign height = BOX_W'(regs[HEIGHT_MSB:HEIGHT_LSB]);
  assign xpos   = BOX_W'(regs[XPOS_MSB:XPOS_LSB]);
  assign ypos   = BOX_W'(regs[YPOS_MSB:YPOS_LSB]);
  assign nchar  = BOX_W'(regs[NCHAR_MSB:NCHAR_LSB]);
  assign xp     = BOX_W'(x);
  assign yp     = BOX_W'(y);

  // Font layers span one glyph cell per character; the product never exceeds 24 bits.
  assign effw   = regs[SPRITE_BIT] ? width : width * nchar;
  assign x_end  = xpos + effw;
  assign y_end  = ypos + height;

  // Right and bottom edges are exclusive, so zero extents can never hit.
  assign hit = regs[POP_BIT] && (xp >= xpos) && (xp < x_end) && (yp >= ypos) && (yp < y_end);

  assign unused_fields = ^{regs[15:2], regs[95:80], regs[127:104]};

endmodule

// File: rtl/layer_scan_sequencer.sv
// Walks every pixel and layer slot of a frame and hands visible (pixel, layer) jobs to the address unit.
module layer_scan_sequencer
  import gpu_layer_pkg::*;
#(
  parameter int NUM_LAYERS = 16,
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int PIX_W      = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  layer_scan_sequencer_if.master        bus,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_LAYERS);

  seq_state_t       state, nxt;
  logic [IDX_W-1:0] layer;
  logic [PIX_W-1:0] x, y;
  layer_regs_t      lreg;
  logic             hit, rd_en, job_valid;
  logic             last_layer, last_x, last_y;

  assign last_layer = (layer == IDX_W'(NUM_LAYERS - 1));
  assign last_x     = (x == PIX_W'(H_ACTIVE - 1));
  assign last_y     = (y == PIX_W'(V_ACTIVE - 1));

  layer_hit_test #(.PIX_W(PIX_W)) u_hit (
    .regs (lreg),
    .x    (x),
    .y    (y),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      layer <= '0;
      x     <= '0;
      y     <= '0;
      lreg  <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (frame_start) begin
            layer <= '0;
            x     <= '0;
            y     <= '0;
          end
        end
        WAIT: lreg <= bus.layer_rd_data;
        ADVANCE: begin
          if (!last_layer) begin
            layer <= layer + 1'b1;
          end else begin
            layer <= '0;
            if (!last_x) begin
              x <= x + 1'b1;
            end else begin
              x <= '0;
              y <= last_y ? '0 : y + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt        = state;
    rd_en      = 1'b0;
    job_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (frame_start) nxt = FETCH;
      FETCH: begin
        rd_en = 1'b1;
        nxt   = WAIT;
      end
      WAIT:    nxt = TEST;
      TEST:    nxt = hit ? ISSUE : ADVANCE;
      ISSUE: begin
        job_valid = 1'b1;
        if (bus.acu_rdy) nxt = ADVANCE;
      end
      ADVANCE: begin
        if (last_layer && last_x && last_y) begin
          frame_done = 1'b1;
          nxt        = IDLE;
        end else begin
          nxt = FETCH;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy               = (state != IDLE);
  assign bus.layer_rd_en    = rd_en;
  assign bus.layer_rd_idx   = layer;
  assign bus.job_valid      = job_valid;
  assign bus.layerRegisters = lreg;
  assign bus.xPixel         = x;
  assign bus.yPixel         = y;
  assign bus.layer_idx      = layer;

endmodule
